if_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the instruction ROM: owns the PC and drives the ROM chip-enable and address.
- Captures the returned instruction word and hands {pc, inst} pairs to the decode stage through a valid/ready handshake, with a small buffer.
- Handles pipeline hold and branch/jump redirect. Sits between the ctrl/branch logic and if_id.

---
 rtl/if_fetch_unit_pkg.sv | 24 ++
 rtl/if_fetch_unit_fifo.sv | 80 ++++++++
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants, state encoding and helpers for the
// instruction-fetch unit and its {pc, inst} buffer.
package if_fetch_unit_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE_N = 1'b0;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// if_fetch_fifo: circular buffer of {pc, inst} pairs between fetch and decode.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   push, push_data      write one entry at the clock edge
//   pop                  drop the head entry (caller guarantees head_valid)
//   flush                empty the buffer; wins over push
//   head_valid/head_data registered head; holds the last shown entry when empty
//   count                current occupancy
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     last_q, last_d;

  assign head_valid = (count_q != '0);
  // Every source of the head is a flop, so rom data never reaches decode
  // combinationally; last_q keeps the outputs stable while empty.
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : last_q;
  assign count      = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = head_valid ? mem_q[rd_ptr_q] : last_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE_N) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, drives the instruction ROM and hands {pc, inst}
// pairs to decode through a valid/ready buffer. Handles hold and redirect.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rom_ce, rom_addr, rom_inst  ROM interface (rom_addr always equals pc)
//   hold                        suppresses new issue only
//   redirect, redirect_pc       branch/jump target load, flushes the buffer
//   if_valid/if_ready           handshake to decode
//   if_pc, if_inst              buffer head
// Build option: IF_SYNC_IMEM_EN selects a synchronous ROM (data one cycle
// after issue); undefined means combinational ROM timing.
//
// state  | meaning
// S_IDLE | out of reset, no issue yet
// S_RUN  | steady state, issue whenever allowed
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0]      rom_inst,
  input  logic                   hold,
  input  logic                   redirect,
  input  logic [INST_ADDR_W-1:0] redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = INST_ADDR_W + INST_W;

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]       count;
  logic                   pop;
  logic                   room;
  logic                   issue;
  logic                   push;
  logic [ENT_W-1:0]       push_data;
  logic [ENT_W-1:0]       head_data;

  assign pop = if_valid && if_ready;

`ifdef IF_SYNC_IMEM_EN
  localparam int OCC_W = CNT_W + 1;
  logic                   inflight_q, inflight_d;
  logic [INST_ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [OCC_W-1:0]       occupancy;

  // The outstanding request already owns a slot; a pop this cycle frees one.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign room      = (occupancy < OCC_W'(FIFO_DEPTH));
  // A response landing in a redirect cycle belongs to the old path; it is
  // killed here (the flush also wins inside the buffer).
  assign push      = inflight_q && !redirect;
  assign push_data = {req_pc_q, rom_inst};

  always_comb begin
    inflight_d = issue;
    req_pc_d   = issue ? pc_q : req_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE_N) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
    end
  end
`else
  assign room      = (count < CNT_W'(FIFO_DEPTH)) || pop;
  assign push      = issue;
  assign push_data = {pc_q, rom_inst};
`endif

  assign issue    = (state_q == S_RUN) && !redirect && !hold && room;
  assign rom_ce   = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE_N) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect),
    .head_valid (if_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign if_pc   = head_data[ENT_W-1:INST_W];
  assign if_inst = head_data[INST_W-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0, redirect = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        rom_ce, if_valid;
  logic [31:0] rom_addr, rom_inst, if_pc, if_inst;

  logic        w_rom_ce, w_valid;
  logic [31:0] w_rom_addr, w_rom_inst, w_pc, w_inst;

  always #5 clk = ~clk;

  // ROM image: word i holds the value i.
  assign rom_inst   = {2'b00, rom_addr[31:2]};
  assign w_rom_inst = {2'b00, w_rom_addr[31:2]};

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n), .rom_ce(w_rom_ce), .rom_addr(w_rom_addr), .rom_inst(w_rom_inst),
    .hold(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .if_valid(w_valid), .if_ready(1'b1), .if_pc(w_pc), .if_inst(w_inst)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: a queue of delivered pairs plus the next PC.
  logic [31:0] m_pc;
  bit          m_started;
  logic [63:0] m_q[$];
  logic [31:0] m_last_pc, m_last_inst;
  logic        e_ce, e_valid;
  logic [31:0] e_pc, e_inst, e_addr;

  task automatic model_reset();
    m_pc = 32'h0; m_started = 0; m_q.delete(); m_last_pc = 32'h0; m_last_inst = 32'h0;
  endtask

  // Expected outputs for the current cycle's inputs, then advance to the next cycle.
  task automatic model_cycle();
    bit pop, issue;
    e_valid = (m_q.size() != 0);
    if (e_valid) begin
      e_pc = m_q[0][63:32]; e_inst = m_q[0][31:0];
      m_last_pc = e_pc; m_last_inst = e_inst;
    end else begin
      e_pc = m_last_pc; e_inst = m_last_inst;
    end
    e_addr = m_pc;
    pop    = e_valid && if_ready;
    issue  = m_started && !redirect && !hold && (m_q.size() < DEPTH || pop);
    e_ce   = issue;
    if (pop) void'(m_q.pop_front());
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc & ~32'h3;
    end else if (issue) begin
      m_q.push_back({m_pc, m_pc >> 2});
      m_pc = m_pc + 32'd4;
    end
    m_started = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 0; redirect = 0; if_ready = 0; redirect_pc = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset rom_ce got %0b exp 0", rom_ce); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset if_valid got %0b exp 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset if_pc got %h exp 0", if_pc); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset if_inst got %h exp 0", if_inst); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset rom_addr got %h exp 0", rom_addr); end
    checks++; if (w_rom_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset wrap rom_addr got %h exp fffffff8", w_rom_addr); end
    model_reset();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      if_ready = 1; hold = 0; redirect = 0;
      #1; model_cycle();
      checks++; if (rom_ce !== e_ce) begin errors++; $display("FAIL stream rom_ce cyc%0d got %0b exp %0b", i, rom_ce, e_ce); end
      checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL stream rom_addr cyc%0d got %h exp %h", i, rom_addr, e_addr); end
      checks++; if (if_valid !== e_valid) begin errors++; $display("FAIL stream if_valid cyc%0d got %0b exp %0b", i, if_valid, e_valid); end
      checks++; if ({if_pc, if_inst} !== {e_pc, e_inst}) begin errors++; $display("FAIL stream head cyc%0d got %h/%h exp %h/%h", i, if_pc, if_inst, e_pc, e_inst); end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_ready = (i >= 5); hold = 0; redirect = 0;
      #1; model_cycle();
      checks++; if (rom_ce !== e_ce) begin errors++; $display("FAIL bp rom_ce cyc%0d got %0b exp %0b", i, rom_ce, e_ce); end
      checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL bp rom_addr cyc%0d got %h exp %h", i, rom_addr, e_addr); end
      checks++; if (if_valid !== e_valid) begin errors++; $display("FAIL bp if_valid cyc%0d got %0b exp %0b", i, if_valid, e_valid); end
      checks++; if ({if_pc, if_inst} !== {e_pc, e_inst}) begin errors++; $display("FAIL bp head cyc%0d got %h/%h exp %h/%h", i, if_pc, if_inst, e_pc, e_inst); end
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hold = 0;
      if_ready    = (i >= 4);
      redirect    = (i == 3);
      redirect_pc = (i == 3) ? 32'h0000_0103 : 32'h0;
      #1; model_cycle();
      checks++; if (rom_ce !== e_ce) begin errors++; $display("FAIL redir rom_ce cyc%0d got %0b exp %0b", i, rom_ce, e_ce); end
      checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL redir rom_addr cyc%0d got %h exp %h", i, rom_addr, e_addr); end
      checks++; if (if_valid !== e_valid) begin errors++; $display("FAIL redir if_valid cyc%0d got %0b exp %0b", i, if_valid, e_valid); end
      checks++; if ({if_pc, if_inst} !== {e_pc, e_inst}) begin errors++; $display("FAIL redir head cyc%0d got %h/%h exp %h/%h", i, if_pc, if_inst, e_pc, e_inst); end
      if (i == 5) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL redir target got v=%0b pc=%h exp v=1 pc=00000100", if_valid, if_pc); end
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      redirect = 0;
      if_ready = (i >= 3);
      hold     = (i >= 3 && i < 7);
      #1; model_cycle();
      checks++; if (rom_ce !== e_ce) begin errors++; $display("FAIL hold rom_ce cyc%0d got %0b exp %0b", i, rom_ce, e_ce); end
      checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL hold rom_addr cyc%0d got %h exp %h", i, rom_addr, e_addr); end
      checks++; if (if_valid !== e_valid) begin errors++; $display("FAIL hold if_valid cyc%0d got %0b exp %0b", i, if_valid, e_valid); end
      checks++; if ({if_pc, if_inst} !== {e_pc, e_inst}) begin errors++; $display("FAIL hold head cyc%0d got %h/%h exp %h/%h", i, if_pc, if_inst, e_pc, e_inst); end
      if (hold) begin
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL hold ce_low cyc%0d got %0b exp 0", i, rom_ce); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if_ready = ($urandom_range(0, 9) < 7);
      hold     = ($urandom_range(0, 9) < 2);
      redirect = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
      #1; model_cycle();
      checks++; if (rom_ce !== e_ce) begin errors++; $display("FAIL rand rom_ce cyc%0d got %0b exp %0b", i, rom_ce, e_ce); end
      checks++; if (rom_addr !== e_addr) begin errors++; $display("FAIL rand rom_addr cyc%0d got %h exp %h", i, rom_addr, e_addr); end
      checks++; if (if_valid !== e_valid) begin errors++; $display("FAIL rand if_valid cyc%0d got %0b exp %0b", i, if_valid, e_valid); end
      checks++; if ({if_pc, if_inst} !== {e_pc, e_inst}) begin errors++; $display("FAIL rand head cyc%0d got %h/%h exp %h/%h", i, if_pc, if_inst, e_pc, e_inst); end
    end
    redirect = 0; hold = 0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL midrst rom_ce got %0b exp 0", rom_ce); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL midrst if_valid got %0b exp 0", if_valid); end
    checks++; if ({if_pc, if_inst} !== 64'h0) begin errors++; $display("FAIL midrst head got %h/%h exp 0/0", if_pc, if_inst); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL midrst rom_addr got %h exp 0", rom_addr); end
    model_reset();
    hold = 0; redirect = 0; if_ready = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    logic [31:0] exp_pc[4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      if_ready = 1; hold = 0; redirect = 0;
      #1; model_cycle();
      checks++; if ({if_valid, if_pc, if_inst} !== {e_valid, e_pc, e_inst}) begin errors++; $display("FAIL wrap main head cyc%0d got %0b/%h/%h exp %0b/%h/%h", i, if_valid, if_pc, if_inst, e_valid, e_pc, e_inst); end
      if (w_valid === 1'b1) begin
        seen.push_back(w_pc);
        checks++; if (w_inst !== (w_pc >> 2)) begin errors++; $display("FAIL wrap inst got %h exp %h", w_inst, w_pc >> 2); end
      end
    end
    checks++;
    if (seen.size() < 4) begin
      errors++; $display("FAIL wrap count got %0d exp >=4", seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (seen[k] !== exp_pc[k]) begin errors++; $display("FAIL wrap pc%0d got %h exp %h", k, seen[k], exp_pc[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_hold();
    test_random();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
